uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 92 +++++++++
 tb/tb_uart_rx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with two-flop input synchronizer, mid-bit sampling and frame-error detection.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state_q, state_d;
  logic rx_m_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  // Counter restarts on every state change and at each data-bit boundary, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: if (cnt_q == HALF) begin
        state_d = rx_s_q ? IDLE : DATA;
        cnt_d   = '0;
        idx_d   = '0;
      end
      DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        sh_d  = {rx_s_q, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = rx_s_q ? IDLE : WAIT_IDLE;
        valid_d = rx_s_q;
        ferr_d  = !rx_s_q;
        data_d  = rx_s_q ? sh_q : data_q;
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with a byte scoreboard and pulse counters.
module tb_uart_rx;
  localparam int C = 16;
  localparam int LAT = 2 + ((C - 1) / 2 + 1) + 9 * C + 2;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, busy;
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int nv = 0;
  int nf = 0;
  int vcyc = 0;
  logic [8:0] sb[$];
  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_in(clk_in), .rst(rst), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  // Pulses are observed on the falling edge, well away from the sampling edge.
  always @(negedge clk_in) begin
    if (rx_valid || frame_err) chk("exclusive", {31'd0, rx_valid && frame_err}, 32'd0);
    if (frame_err) nf++;
    if (rx_valid) begin
      nv++;
      vcyc = cyc;
      chk("sb_data", {23'd0, 1'b0, rx_data}, {23'd0, sb.size() > 0 ? sb.pop_front() : 9'h100});
    end
  end
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    wait_cyc(C);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(C);
    end
    rx = stop;
    wait_cyc(C);
  endtask
  initial begin
    int bc;
    int t0;
    wait_cyc(3);
    chk("rst_data", {24'd0, rx_data}, 32'h00);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_cyc(5);
    sb.push_back(9'h0A5);
    send_frame(8'hA5, 1'b1);
    wait_cyc(4);
    chk("a5_nv", nv, 1);
    chk("a5_nf", nf, 0);
    chk("a5_busy", {31'd0, busy}, 32'd0);
    chk("a5_data", {24'd0, rx_data}, 32'hA5);
    sb.push_back(9'h000);
    sb.push_back(9'h0FF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(4);
    chk("b2b_nv", nv, 3);
    chk("b2b_nf", nf, 0);
    chk("b2b_data", {24'd0, rx_data}, 32'hFF);
    rx = 1'b0;
    bc = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) rx = 1'b1;
      wait_cyc(1);
      bc += int'(busy);
    end
    chk("glitch_busy_range", {31'd0, bc > 0 && bc < 12}, 32'd1);
    chk("glitch_idle", {31'd0, busy}, 32'd0);
    chk("glitch_nv", nv, 3);
    chk("glitch_nf", nf, 0);
    chk("glitch_data", {24'd0, rx_data}, 32'hFF);
    sb.push_back(9'h011);
    send_frame(8'h11, 1'b1);
    wait_cyc(2);
    chk("x11_data", {24'd0, rx_data}, 32'h11);
    send_frame(8'h3C, 1'b0);
    wait_cyc(40);
    chk("brk_nf", nf, 1);
    chk("brk_nv", nv, 4);
    chk("brk_data", {24'd0, rx_data}, 32'h11);
    chk("brk_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    wait_cyc(4);
    chk("brk_release_busy", {31'd0, busy}, 32'd0);
    chk("brk_nf_once", nf, 1);
    rx = 1'b0;
    wait_cyc(C);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      wait_cyc(C);
    end
    rx = 1'b1;
    wait_cyc(C / 2);
    rst = 1'b1;
    wait_cyc(1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_data", {24'd0, rx_data}, 32'h00);
    rst = 1'b0;
    wait_cyc(2 * C);
    chk("rst_mid_nv", nv, 4);
    chk("rst_mid_nf", nf, 1);
    sb.push_back(9'h05A);
    send_frame(8'h5A, 1'b1);
    wait_cyc(4);
    chk("x5a_data", {24'd0, rx_data}, 32'h5A);
    chk("x5a_nv", nv, 5);
    sb.push_back(9'h081);
    t0 = cyc;
    send_frame(8'h81, 1'b1);
    wait_cyc(4);
    chk("x81_nv", nv, 6);
    chk("x81_latency_ok", {31'd0, (vcyc - t0) >= LAT - 1 && (vcyc - t0) <= LAT + 1}, 32'd1);
    chk("x81_data", {24'd0, rx_data}, 32'h81);
    chk("sb_empty", sb.size(), 0);
    chk("final_nf", nf, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
